// File: rtl/fd_pkg.sv
// fd_pkg: shared constants for the fetch/decode stage.
//   Opcode values, execute-stage class codes, FSM state encodings,
//   the default reset PC and sign-extension helpers.
package fd_pkg;

  localparam int unsigned XLEN   = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned TYPE_W = 5;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned ST_W   = 3;

  localparam logic [XLEN-1:0] RESET_IP_DEFAULT = 16'h3000;

  // Opcodes, inst[15:12]
  localparam logic [OP_W-1:0] OP_BR  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_JSR = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND = 4'b0101;
  localparam logic [OP_W-1:0] OP_NOT = 4'b1001;
  localparam logic [OP_W-1:0] OP_JMP = 4'b1100;
  localparam logic [OP_W-1:0] OP_LEA = 4'b1110;

  // Class codes understood by the execute stage
  localparam logic [TYPE_W-1:0] T_JMP     = 5'b00000;
  localparam logic [TYPE_W-1:0] T_NOT     = 5'b00100;
  localparam logic [TYPE_W-1:0] T_LEA     = 5'b00101;
  localparam logic [TYPE_W-1:0] T_ALU_REG = 5'b00110;
  localparam logic [TYPE_W-1:0] T_ALU_IMM = 5'b00111;
  localparam logic [TYPE_W-1:0] T_BR      = 5'b01001;
  localparam logic [TYPE_W-1:0] T_JSR     = 5'b10001;
  localparam logic [TYPE_W-1:0] T_ILLEGAL = 5'b11111;

  // FSM states; HALT is only reachable when illegal ops trap
  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH   = 3'd1;
  localparam logic [ST_W-1:0] ST_ISSUE   = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT_IP = 3'd3;
  localparam logic [ST_W-1:0] ST_HALT    = 3'd4;

  function automatic logic [XLEN-1:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

endpackage

// File: rtl/fd_decoder.sv
// fd_decoder: purely combinational instruction decoder.
//   inst       in   16  instruction word
//   inst_type  out  5   class code ('type' is a reserved word)
//   sr1/sr2/dr out  3   register fields, 0 when unused
//   imm        out  16  sign-extended immediate/offset, 0 when unused
//   illegal    out  1   opcode not recognised
module fd_decoder
  import fd_pkg::*;
(
  input  logic [XLEN-1:0]   inst,
  output logic [TYPE_W-1:0] inst_type,
  output logic [REG_W-1:0]  sr1,
  output logic [REG_W-1:0]  sr2,
  output logic [REG_W-1:0]  dr,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  logic [OP_W-1:0] op;
  assign op = inst[15:12];

  // Field extraction per opcode; everything not used by an op stays 0
  always_comb begin
    inst_type = T_ILLEGAL;
    sr1       = '0;
    sr2       = '0;
    dr        = '0;
    imm       = '0;
    illegal   = 1'b0;
    case (op)
      OP_ADD, OP_AND: begin
        dr  = inst[11:9];
        sr1 = inst[8:6];
        if (inst[5]) begin
          inst_type = T_ALU_IMM;
          imm       = sext5(inst[4:0]);
        end else begin
          inst_type = T_ALU_REG;
          sr2       = inst[2:0];
        end
      end
      OP_NOT: begin
        inst_type = T_NOT;
        dr        = inst[11:9];
        sr1       = inst[8:6];
      end
      OP_LEA: begin
        inst_type = T_LEA;
        dr        = inst[11:9];
        imm       = sext9(inst[8:0]);
      end
      OP_BR: begin
        inst_type = T_BR;
        imm       = sext9(inst[8:0]);
      end
      OP_JSR: begin
        inst_type = T_JSR;
        dr        = REG_W'(7);
        imm       = sext11(inst[10:0]);
      end
      OP_JMP: begin
        inst_type = T_JMP;
        sr1       = inst[8:6];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch + decode front end.
//   Fetches the word at pc, decodes it, holds the bundle until the execute
//   stage accepts it, then waits for the resolved next_IP.
//   Ports: clk, rst_n (sync, active low); imem_req/imem_addr/imem_ack/
//   imem_rdata instruction memory; inst, inst_type ('type' is a reserved
//   word), SR1, SR2, DR, imm, IP, out_valid/out_ready decoded bundle;
//   ip_valid/next_IP redirect from execute; illegal sticky flag.
//   Macro FD_ILLEGAL_TRAP_EN: illegal ops halt the stage instead of being
//   skipped by NOP_ILLEGAL_SKIP.
module fetch_decode
  import fd_pkg::*;
#(
  parameter logic [15:0] RESET_IP         = RESET_IP_DEFAULT,
  parameter int unsigned NOP_ILLEGAL_SKIP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [XLEN-1:0]   inst,
  output logic [TYPE_W-1:0] inst_type,
  output logic [REG_W-1:0]  SR1,
  output logic [REG_W-1:0]  SR2,
  output logic [REG_W-1:0]  DR,
  output logic [XLEN-1:0]   imm,
  output logic [XLEN-1:0]   IP,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              ip_valid,
  input  logic [XLEN-1:0]   next_IP,
  output logic              illegal
);

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_nxt;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_nxt;
  logic              load_bundle;
  logic              illegal_nxt;

  logic [TYPE_W-1:0] dec_type;
  logic [REG_W-1:0]  dec_sr1;
  logic [REG_W-1:0]  dec_sr2;
  logic [REG_W-1:0]  dec_dr;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_illegal;

  // Decode the returning word directly so the bundle is ready one cycle after ack
  fd_decoder u_dec (
    .inst      (imem_rdata),
    .inst_type (dec_type),
    .sr1       (dec_sr1),
    .sr2       (dec_sr2),
    .dr        (dec_dr),
    .imm       (dec_imm),
    .illegal   (dec_illegal)
  );

  assign imem_addr = pc;

  // Next-state and datapath control
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    load_bundle = 1'b0;
    illegal_nxt = illegal;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          if (dec_illegal) begin
`ifdef FD_ILLEGAL_TRAP_EN
            state_nxt   = ST_HALT;
            illegal_nxt = 1'b1;
`else
            pc_nxt    = pc + XLEN'(NOP_ILLEGAL_SKIP);
            state_nxt = ST_FETCH;
`endif
          end else begin
            load_bundle = 1'b1;
            state_nxt   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (out_ready) begin
          // A redirect arriving with the handshake bypasses WAIT_IP
          if (ip_valid) begin
            pc_nxt    = next_IP;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WAIT_IP;
          end
        end
      end
      ST_WAIT_IP: begin
        if (ip_valid) begin
          pc_nxt    = next_IP;
          state_nxt = ST_FETCH;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, pc and registered outputs; request/valid track the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_IP;
      imem_req  <= 1'b0;
      out_valid <= 1'b0;
      inst      <= '0;
      inst_type <= '0;
      SR1       <= '0;
      SR2       <= '0;
      DR        <= '0;
      imm       <= '0;
      IP        <= '0;
      illegal   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      imem_req  <= (state_nxt == ST_FETCH);
      out_valid <= (state_nxt == ST_ISSUE);
      illegal   <= illegal_nxt;
      if (load_bundle) begin
        inst      <= imem_rdata;
        inst_type <= dec_type;
        SR1       <= dec_sr1;
        SR2       <= dec_sr2;
        DR        <= dec_dr;
        imm       <= dec_imm;
        IP        <= pc + XLEN'(1);
      end
    end
  end

endmodule
